sha256_msg_padder: RTL and testbench

//  Upstream feeder for the SHA-256 compression core. On start, reads NUM_OF_WORDS 32-bit message

---
 rtl/sha256_msg_padder.sv | 184 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fetches NUM_OF_WORDS words from memory,
// appends marker, zero fill and 64-bit length, emits 512-bit blocks.
// Ports: clk, reset_n (async low), start, message_addr;
//   memory: mem_addr, mem_we, mem_read_data (1-cycle latency);
//   block: blk_data, blk_valid, blk_ready, blk_last, blk_idx;
//   status: busy, done.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic [15:0]  mem_addr,
  output logic         mem_we,
  input  logic [31:0]  mem_read_data,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_last,
  output logic [7:0]   blk_idx,
  output logic         busy,
  output logic         done
);

  localparam int NB = (NUM_OF_WORDS + 18) / 16;
  localparam logic [63:0] LEN =
    64'(NUM_OF_WORDS) * 64'd32;
  localparam logic [15:0] N16 = 16'(NUM_OF_WORDS);
  localparam logic [7:0] LAST_IDX = 8'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  k_q;
  logic [15:0] base_q;
  logic [7:0]  idx_q;
  logic [15:0] addr_q;
  logic        done_q;
  logic [31:0] blk_q [16];

  logic        is_last;
  logic        fire;
  logic [15:0] blk_base;
  logic [15:0] cur_g;
  logic [15:0] wr_g;
  logic [15:0] nxt_g;
  logic [15:0] nxt_blk;
  logic [3:0]  wr_w;

  function automatic logic [31:0] pad_word(
    input logic [15:0] g,
    input logic [3:0]  w,
    input logic        last
  );
    logic [31:0] r;
    r = '0;
    if (g == N16)
      r = 32'h8000_0000;
    else if (last && w == 4'd14)
      r = LEN[63:32];
    else if (last && w == 4'd15)
      r = LEN[31:0];
    return r;
  endfunction

  assign is_last  = (idx_q == LAST_IDX);
  assign fire     = (state_q == PRESENT) & blk_ready;
  assign blk_base = {4'b0, idx_q, 4'b0};
  assign cur_g    = blk_base + 16'(k_q);
  assign wr_g     = cur_g - 16'd1;
  assign nxt_g    = cur_g + 16'd1;
  assign nxt_blk  = {4'b0, idx_q + 8'd1, 4'b0};
  // k=16 wraps to 15: the last word lands on the final fetch edge
  assign wr_w     = k_q[3:0] - 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) state_d = FETCH;
      FETCH:
        if (k_q == 5'd16) state_d = PRESENT;
      PRESENT:
        if (blk_ready)
          state_d = is_last ? IDLE : FETCH;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    blk_valid = 1'b0;
    unique case (1'b1)
      (state_q == FETCH): begin
        busy = 1'b1;
      end
      (state_q == PRESENT): begin
        busy      = 1'b1;
        blk_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    blk_last = blk_valid & is_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q    <= '0;
      base_q <= '0;
      idx_q  <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 16; i++)
        blk_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= message_addr;
            addr_q <= message_addr;
            idx_q  <= '0;
            k_q    <= '0;
          end
        end
        FETCH: begin
          k_q <= (k_q == 5'd16) ? 5'd0 : k_q + 5'd1;
          if (k_q != 5'd0) begin
            if (wr_g < N16)
              blk_q[wr_w] <= mem_read_data;
            else
              blk_q[wr_w] <= pad_word(wr_g, wr_w, is_last);
          end
          // issue the next read one cycle ahead of its capture
          if (k_q < 5'd15 && nxt_g < N16)
            addr_q <= base_q + nxt_g;
        end
        PRESENT: begin
          if (fire) begin
            if (is_last) begin
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 8'd1;
              k_q   <= '0;
              if (nxt_blk < N16)
                addr_q <= base_q + nxt_blk;
            end
          end
        end
        default: begin
          k_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    blk_data = '0;
    for (int w = 0; w < 16; w++)
      blk_data[(15 - w) * 32 +: 32] = blk_q[w];
  end

  assign mem_addr = addr_q;
  assign mem_we   = 1'b0;
  assign blk_idx  = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: four instances with
// N = 20, 13, 14, 16 and a registered memory model per instance.
module tb_sha256_msg_padder;

  logic clk;
  logic rst_n;
  logic         start     [4];
  logic [15:0]  maddr     [4];
  logic [15:0]  mem_addr  [4];
  logic         mem_we    [4];
  logic [31:0]  rdata     [4];
  logic [511:0] blk_data  [4];
  logic         valid     [4];
  logic         ready     [4];
  logic         last      [4];
  logic [7:0]   idx       [4];
  logic         busy      [4];
  logic         done      [4];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memval(input logic [15:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int NW = (i == 0) ? 20 :
                        (i == 1) ? 13 :
                        (i == 2) ? 14 : 16;
    sha256_msg_padder #(.NUM_OF_WORDS(NW)) u_dut (
      .clk           (clk),
      .reset_n       (rst_n),
      .start         (start[i]),
      .message_addr  (maddr[i]),
      .mem_addr      (mem_addr[i]),
      .mem_we        (mem_we[i]),
      .mem_read_data (rdata[i]),
      .blk_data      (blk_data[i]),
      .blk_valid     (valid[i]),
      .blk_ready     (ready[i]),
      .blk_last      (last[i]),
      .blk_idx       (idx[i]),
      .busy          (busy[i]),
      .done          (done[i])
    );
    always @(posedge clk)
      rdata[i] <= memval(mem_addr[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [511:0] got,
    input logic [511:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_blk(
    input int n,
    input logic [15:0] base,
    input int b
  );
    logic [511:0] r;
    logic [31:0]  wd;
    int nb;
    int g;
    nb = (n + 18) / 16;
    r  = '0;
    for (int w = 0; w < 16; w++) begin
      g  = b * 16 + w;
      wd = 32'h0;
      if (g < n)
        wd = memval(base + 16'(g));
      else if (g == n)
        wd = 32'h8000_0000;
      else if (b == nb - 1 && w == 15)
        wd = 32'(n * 32);
      r[(15 - w) * 32 +: 32] = wd;
    end
    return r;
  endfunction

  task automatic wait_valid(input int i, output int cnt);
    cnt = 0;
    while (!valid[i] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run_msg(
    input int          i,
    input int          n,
    input logic [15:0] base,
    input int          nb,
    input int          hold,
    input logic [31:0] lenw
  );
    int cnt;
    logic [511:0] e;
    @(negedge clk);
    maddr[i] = base;
    start[i] = 1'b1;
    ready[i] = (hold == 0);
    @(negedge clk);
    start[i] = 1'b0;
    chk("busy_run", busy[i], 1'b1);
    for (int b = 0; b < nb; b++) begin
      wait_valid(i, cnt);
      chk("latency", cnt, 17);
      e = exp_blk(n, base, b);
      if (b == 0 && hold > 0) begin
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          if (c == 3) begin
            maddr[i] = base ^ 16'h1234;
            start[i] = 1'b1;
          end else begin
            start[i] = 1'b0;
          end
          chk("hold_valid", valid[i], 1'b1);
          chk("hold_idx", idx[i], 8'd0);
          chk("hold_data", blk_data[i], e);
        end
        start[i] = 1'b0;
        ready[i] = 1'b1;
      end
      chk("valid", valid[i], 1'b1);
      chk("idx", idx[i], 8'(b));
      chk("last", last[i], (b == nb - 1));
      chk("data", blk_data[i], e);
      if (b == nb - 1)
        chk("lenw", blk_data[i][31:0], lenw);
      @(negedge clk);
      chk("valid_drop", valid[i], 1'b0);
      if (b == nb - 1) begin
        chk("done", done[i], 1'b1);
        chk("busy_end", busy[i], 1'b0);
        @(negedge clk);
        chk("done_pulse", done[i], 1'b0);
      end else begin
        chk("done_mid", done[i], 1'b0);
        chk("busy_mid", busy[i], 1'b1);
      end
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      maddr[i] = 16'h0;
      ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_addr", mem_addr[i], 16'h0);
      chk("rst_we", mem_we[i], 1'b0);
      chk("rst_data", blk_data[i], 512'h0);
      chk("rst_ctl", {valid[i], last[i], busy[i], done[i]}, 4'h0);
      chk("rst_idx", idx[i], 8'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_msg(0, 20, 16'h0000, 2, 0, 32'h0000_0280);
    run_msg(1, 13, 16'h0020, 1, 0, 32'h0000_01A0);
    chk("n13_mark", blk_data[1][511-13*32 -: 32], 32'h8000_0000);
    run_msg(2, 14, 16'h0030, 2, 0, 32'h0000_01C0);
    run_msg(3, 16, 16'h0040, 2, 0, 32'h0000_0200);
    chk("n16_mark", blk_data[3][511:480], 32'h8000_0000);
    run_msg(3, 16, 16'hFFF8, 2, 0, 32'h0000_0200);
    run_msg(0, 20, 16'h0200, 2, 10, 32'h0000_0280);

    @(negedge clk);
    maddr[0] = 16'h0040;
    start[0] = 1'b1;
    ready[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_valid(0, cnt);
    chk("abort_lat", cnt, 17);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("abort_busy", busy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_addr", mem_addr[0], 16'h0);
    chk("abort_data", blk_data[0], 512'h0);
    chk("abort_ctl",
        {valid[0], last[0], busy[0], done[0]}, 4'h0);
    chk("abort_idx", idx[0], 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_msg(0, 20, 16'h0100, 2, 0, 32'h0000_0280);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
